banked_rr_memory: RTL and testbench
===================================

// Module: banked_rr_memory
// PURPOSE
//  Banked RAM shared by READ_PORTS readers and WRITE_PORTS writers. Each bank is 1R1W
//  and has one round-robin arbiter per direction, so conflicting requests stall with
//  ready=0 instead of colliding. It is the arbitrated successor to the unarbitrated
//  multibank store and sits between core load/store ports and on-chip data storage.
// PARAMETERS
//  READ_PORTS   3   number of read requesters
//  WRITE_PORTS  3   number of write requesters
//  DATA_WIDTH   32  word width
//  ADDR_WIDTH   6   global word address width
//  BANKS        4   number of banks (>=1, any value)
//  INTERLEAVE   1   1: bank=addr%BANKS, row=addr/BANKS; 0: bank=addr/BANK_SIZE, row=addr%BANK_SIZE
//  BANK_SIZE    localparam ceil(2**ADDR_WIDTH/BANKS); ROW_W=$clog2(BANK_SIZE) (min 1)
// PORTS
//  clk       in   1                  single clock, all state on rising edge
//  rst       in   1                  asynchronous, active-low reset
//  r_addr    in   RP x ADDR_WIDTH    read address per port
//  r_avalid  in   RP                 read request valid
//  r_aready  out  RP                 read request accepted this cycle
//  r_dvalid  out  RP                 read data valid (one cycle after acceptance)
//  r_data    out  RP x DATA_WIDTH    read data
//  w_addr    in   WP x ADDR_WIDTH    write address
//  w_data    in   WP x DATA_WIDTH    write data
//  w_valid   in   WP                 write request valid
//  w_ready   out  WP                 write accepted (committed at this clock edge)
// BEHAVIOUR
//  - Reset (rst=0, async): r_dvalid=0, r_data=0, all arbiter pointers=0, counters=0.
//    Memory contents are not reset. r_aready/w_ready are combinational and stay 0 while rst=0.
//  - Decode: each request maps to (bank,row) per INTERLEAVE. All 2**ADDR_WIDTH addresses are legal.
//  - Per bank per cycle: at most 1 read grant and 1 write grant. The arbiter starts its
//    search at ptr and takes the first requesting port at or after it, wrapping modulo
//    the port count. On a grant, ptr <= granted+1 (mod ports). With no grant, ptr holds.
//  - Handshake: aready/ready = avalid/valid & grant, with a combinational path from
//    valid to ready. A refused requester must hold addr/data/valid stable until it sees
//    ready=1. There is no queueing inside the block.
//  - Read latency: accepted at edge N, so r_dvalid=1 with r_data in cycle N+1 for exactly
//    one cycle. Otherwise r_dvalid=0 and r_data holds its last value.
//  - Same-row read and write granted in the same cycle: the read returns the OLD data
//    (read-first). The new data is visible to reads accepted at N+1 and later.
//  - Two writers to the same bank: only one is granted. The loser retries and is
//    guaranteed a grant within WRITE_PORTS cycles (starvation-free). Reads follow the
//    same rule with READ_PORTS.
//  - Requests to different banks never block each other, so up to min(RP,BANKS) reads
//    and min(WP,BANKS) writes are accepted per cycle.
//  - Reset asserted mid-operation: a pending r_dvalid is dropped, and a write that is
//    not yet at its clock edge is not committed.
// CONFIGURATION
//  MBM_PERF_CNT_EN defined: adds output conflict_cnt [BANKS x 16]. Each bank counts
//    cycles in which at least one valid request to that bank (read or write) was refused.
//    The count saturates at 16'hFFFF and is cleared by rst.
//  MBM_PERF_CNT_EN undefined: the port and the counters are absent, and the behaviour is
//    otherwise identical.
// STRUCTURE
//  - Package multibank_pkg:
//    - bank_of()/row_of() functions parametrised by INTERLEAVE/BANKS;
//    - the typedef for the bank index;
//    - the CNT_W=16 constant.
//  - Sub-module rr_arbiter #(N): inputs req[N], a registered pointer and clk/rst;
//    output one-hot gnt[N]. Instantiated twice per bank (read and write).
//  - Top level: the decode, the per-bank arrays mem[BANKS][BANK_SIZE], registered read
//    data with a port-id tag for the return mux, and ready OR-reduction across banks.
// TESTING
//  - Reset, then write addr 5 = 0xDEADBEEF on port 0, then read addr 5 on port 1 ->
//    w_ready=1 same cycle, r_dvalid[1]=1 with 0xDEADBEEF exactly one cycle after aready.
//  - INTERLEAVE=1, BANKS=4, reads to 0,1,2 on ports 0-2 in one cycle -> all three
//    aready=1, with three dvalids the next cycle.
//  - Three writers to addrs 0,4,8 (all bank 0) held valid -> w_ready one-hot in order
//    port0, port1, port2 over three cycles; then read back each value correctly.
//  - Same cycle: write 0x1 to addr 3 and read addr 3, with old value 0x7 ->
//    read returns 0x7, and a read on the next cycle returns 0x1.
//  - Assert rst=0 while r_dvalid is pending -> r_dvalid=0 and r_data=0 immediately,
//    pointers=0; after release, port 0 wins the first conflict.
//  - MBM_PERF_CNT_EN: two readers held on bank 2 for 10 cycles ->
//    conflict_cnt[2]=10 and all other banks read 0.

Source files
------------

// File: rtl/multibank_pkg.sv
// Shared decode helpers, bank-index type and counter width for the banked RR memory.
package multibank_pkg;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned BANK_IDX_W = 8;

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  // Bank selection: low-order interleave or contiguous blocks of bank_size words.
  function automatic bank_idx_t bank_of(input int unsigned addr, input int unsigned banks,
                                        input int unsigned bank_size, input bit interleave);
    int unsigned b;
    if (interleave) b = addr % banks;
    else            b = addr / bank_size;
    return BANK_IDX_W'(b);
  endfunction

  function automatic int unsigned row_of(input int unsigned addr, input int unsigned banks,
                                         input int unsigned bank_size, input bit interleave);
    int unsigned r;
    if (interleave) r = addr / banks;
    else            r = addr % bank_size;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] sel;
  logic             found;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr;
    sel      = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      sel = PTR_W'((32'(ptr) + i) % N);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
        ptr_next = PTR_W'((32'(sel) + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= '0;
    else      ptr <= ptr_next;
  end

endmodule

// File: rtl/banked_rr_memory.sv
// Banked 1R1W-per-bank RAM with per-bank round-robin read/write arbitration.
// Optional MBM_PERF_CNT_EN adds per-bank refused-request cycle counters.
module banked_rr_memory
  import multibank_pkg::*;
#(
  parameter int unsigned READ_PORTS  = 3,
  parameter int unsigned WRITE_PORTS = 3,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned BANKS       = 4,
  parameter int unsigned INTERLEAVE  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0]  r_addr,
  input  logic [READ_PORTS-1:0]                  r_avalid,
  output logic [READ_PORTS-1:0]                  r_aready,
  output logic [READ_PORTS-1:0]                  r_dvalid,
  output logic [READ_PORTS-1:0][DATA_WIDTH-1:0]  r_data,
  input  logic [WRITE_PORTS-1:0][ADDR_WIDTH-1:0] w_addr,
  input  logic [WRITE_PORTS-1:0][DATA_WIDTH-1:0] w_data,
  input  logic [WRITE_PORTS-1:0]                 w_valid,
  output logic [WRITE_PORTS-1:0]                 w_ready
`ifdef MBM_PERF_CNT_EN
  ,
  output logic [BANKS-1:0][CNT_W-1:0]            conflict_cnt
`endif
);

  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
  localparam int unsigned BANK_SIZE = (DEPTH + BANKS - 1) / BANKS;
  localparam int unsigned ROW_W     = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
  localparam int unsigned TAG_W     = (READ_PORTS > 1) ? $clog2(READ_PORTS) : 1;

  bank_idx_t                              r_bank [READ_PORTS];
  bank_idx_t                              w_bank [WRITE_PORTS];
  logic [READ_PORTS-1:0][ROW_W-1:0]       r_row;
  logic [WRITE_PORTS-1:0][ROW_W-1:0]      w_row;
  logic [BANKS-1:0][READ_PORTS-1:0]       r_req, r_gnt;
  logic [BANKS-1:0][WRITE_PORTS-1:0]      w_req, w_gnt;
  logic [BANKS-1:0][ROW_W-1:0]            rd_row, wr_row;
  logic [BANKS-1:0][TAG_W-1:0]            rd_tag;
  logic [BANKS-1:0][DATA_WIDTH-1:0]       rd_word, wr_data;
  logic [BANKS-1:0]                       rd_en, wr_en;

  // Address decode; requests are masked while reset is held.
  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      r_bank[p] = bank_of(32'(r_addr[p]), BANKS, BANK_SIZE, INTERLEAVE != 0);
      r_row[p]  = ROW_W'(row_of(32'(r_addr[p]), BANKS, BANK_SIZE, INTERLEAVE != 0));
    end
    for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
      w_bank[p] = bank_of(32'(w_addr[p]), BANKS, BANK_SIZE, INTERLEAVE != 0);
      w_row[p]  = ROW_W'(row_of(32'(w_addr[p]), BANKS, BANK_SIZE, INTERLEAVE != 0));
    end
    for (int unsigned b = 0; b < BANKS; b++) begin
      for (int unsigned p = 0; p < READ_PORTS; p++)
        r_req[b][p] = rst & r_avalid[p] & (r_bank[p] == BANK_IDX_W'(b));
      for (int unsigned p = 0; p < WRITE_PORTS; p++)
        w_req[b][p] = rst & w_valid[p] & (w_bank[p] == BANK_IDX_W'(b));
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [BANK_SIZE];

    rr_arbiter #(.N(READ_PORTS)) u_rd_arb (
      .clk (clk),
      .rst (rst),
      .req (r_req[b]),
      .gnt (r_gnt[b])
    );

    rr_arbiter #(.N(WRITE_PORTS)) u_wr_arb (
      .clk (clk),
      .rst (rst),
      .req (w_req[b]),
      .gnt (w_gnt[b])
    );

    // Read-first: the combinational read sees the array before this edge's write.
    always_ff @(posedge clk) begin
      if (wr_en[b]) mem[wr_row[b]] <= wr_data[b];
    end

    assign rd_word[b] = mem[rd_row[b]];
  end

  // Per-bank port select plus ready OR-reduction across banks.
  always_comb begin
    r_aready = '0;
    w_ready  = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      rd_en[b]   = |r_gnt[b];
      wr_en[b]   = |w_gnt[b];
      rd_row[b]  = '0;
      rd_tag[b]  = '0;
      wr_row[b]  = '0;
      wr_data[b] = '0;
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
        if (r_gnt[b][p]) begin
          rd_row[b] = r_row[p];
          rd_tag[b] = TAG_W'(p);
        end
      end
      for (int unsigned p = 0; p < WRITE_PORTS; p++) begin
        if (w_gnt[b][p]) begin
          wr_row[b]  = w_row[p];
          wr_data[b] = w_data[p];
        end
      end
      r_aready = r_aready | r_gnt[b];
      w_ready  = w_ready  | w_gnt[b];
    end
  end

  // Return path: bank word steered to its requester by the port tag, held until the next hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dvalid <= '0;
      r_data   <= '0;
    end else begin
      r_dvalid <= r_aready;
      for (int unsigned b = 0; b < BANKS; b++) begin
        if (rd_en[b]) r_data[rd_tag[b]] <= rd_word[b];
      end
    end
  end

`ifdef MBM_PERF_CNT_EN
  logic [BANKS-1:0] refused;

  always_comb begin
    for (int unsigned b = 0; b < BANKS; b++)
      refused[b] = (|(r_req[b] & ~r_gnt[b])) | (|(w_req[b] & ~w_gnt[b]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_cnt <= '0;
    end else begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        if (refused[b] && (conflict_cnt[b] != {CNT_W{1'b1}}))
          conflict_cnt[b] <= conflict_cnt[b] + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_banked_rr_memory.sv
// Directed plus randomized bench for banked_rr_memory against a behavioural model.
module tb_banked_rr_memory;

  localparam int RP = 3;
  localparam int WP = 3;
  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NB = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [RP-1:0][AW-1:0] r_addr = '0;
  logic [RP-1:0]         r_avalid = '0;
  logic [RP-1:0]         r_aready;
  logic [RP-1:0]         r_dvalid;
  logic [RP-1:0][DW-1:0] r_data;
  logic [WP-1:0][AW-1:0] w_addr = '0;
  logic [WP-1:0][DW-1:0] w_data = '0;
  logic [WP-1:0]         w_valid = '0;
  logic [WP-1:0]         w_ready;
`ifdef MBM_PERF_CNT_EN
  logic [NB-1:0][15:0]   conflict_cnt;
`endif

  banked_rr_memory #(
    .READ_PORTS(RP), .WRITE_PORTS(WP), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .BANKS(NB), .INTERLEAVE(1)
  ) dut (
    .clk(clk), .rst(rst),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_aready(r_aready),
    .r_dvalid(r_dvalid), .r_data(r_data),
    .w_addr(w_addr), .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready)
`ifdef MBM_PERF_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: word array, per-bank RR pointers, expected read-return registers.
  logic [DW-1:0] mm [64];
  int            rptr [NB];
  int            wptr [NB];
  int            e_cnt [NB];
  logic [RP-1:0] e_dv;
  logic [DW-1:0] e_rd [RP];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: entered at negedge with inputs set, returns at the following negedge.
  task automatic step(output logic [RP-1:0] er, output logic [WP-1:0] ew,
                      output logic [RP-1:0] obs_r, output logic [WP-1:0] obs_w);
    int nr [NB];
    int nw [NB];
    logic [NB-1:0] refused;
    er = '0; ew = '0; refused = '0;
    #1;
    for (int b = 0; b < NB; b++) begin
      bit fr, fw;
      fr = 1'b0; fw = 1'b0;
      nr[b] = rptr[b]; nw[b] = wptr[b];
      for (int i = 0; i < RP; i++) begin
        int p;
        p = (rptr[b] + i) % RP;
        if (r_avalid[p] && (int'(r_addr[p]) % NB) == b) begin
          if (!fr) begin er[p] = 1'b1; nr[b] = (p + 1) % RP; fr = 1'b1; end
          else refused[b] = 1'b1;
        end
      end
      for (int i = 0; i < WP; i++) begin
        int p;
        p = (wptr[b] + i) % WP;
        if (w_valid[p] && (int'(w_addr[p]) % NB) == b) begin
          if (!fw) begin ew[p] = 1'b1; nw[b] = (p + 1) % WP; fw = 1'b1; end
          else refused[b] = 1'b1;
        end
      end
    end
    obs_r = r_aready;
    obs_w = w_ready;
    chk("r_aready", 64'(obs_r), 64'(er));
    chk("w_ready", 64'(obs_w), 64'(ew));
    @(posedge clk);
    for (int p = 0; p < RP; p++) if (er[p]) e_rd[p] = mm[r_addr[p]];
    e_dv = er;
    for (int p = 0; p < WP; p++) if (ew[p]) mm[w_addr[p]] = w_data[p];
    for (int b = 0; b < NB; b++) begin
      rptr[b] = nr[b];
      wptr[b] = nw[b];
      if (refused[b] && e_cnt[b] < 65535) e_cnt[b]++;
    end
    #1;
    chk("r_dvalid", 64'(r_dvalid), 64'(e_dv));
    for (int p = 0; p < RP; p++) chk($sformatf("r_data%0d", p), 64'(r_data[p]), 64'(e_rd[p]));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    r_avalid = '1;
    w_valid  = '1;
    #1;
    chk("rst_aready", 64'(r_aready), 64'(0));
    chk("rst_wready", 64'(w_ready), 64'(0));
    chk("rst_dvalid", 64'(r_dvalid), 64'(0));
    for (int p = 0; p < RP; p++) chk($sformatf("rst_rdata%0d", p), 64'(r_data[p]), 64'(0));
    for (int b = 0; b < NB; b++) begin rptr[b] = 0; wptr[b] = 0; e_cnt[b] = 0; end
    e_dv = '0;
    for (int p = 0; p < RP; p++) e_rd[p] = '0;
    r_avalid = '0;
    w_valid  = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [RP-1:0] er, obr;
  logic [WP-1:0] ew, obw;
  logic [DW-1:0] v0, v4, v8;

  initial begin
    #2;
    do_reset();

    // Fill every address so all later reads have a known model value.
    for (int a = 0; a < 64; a++) begin
      w_valid = 3'b001; w_addr[0] = AW'(a); w_data[0] = $urandom;
      step(er, ew, obr, obw);
    end
    w_valid = '0;

    // Write then read address 5.
    w_valid = 3'b001; w_addr[0] = 6'd5; w_data[0] = 32'hDEADBEEF;
    step(er, ew, obr, obw);
    chk("wr5_ready", 64'(obw), 64'(3'b001));
    w_valid = '0;
    r_avalid = 3'b010; r_addr[1] = 6'd5;
    step(er, ew, obr, obw);
    chk("rd5_aready", 64'(obr), 64'(3'b010));
    chk("rd5_dvalid", 64'(r_dvalid[1]), 64'(1));
    chk("rd5_data", 64'(r_data[1]), 64'(32'hDEADBEEF));
    r_avalid = '0;
    step(er, ew, obr, obw);
    chk("rd5_dvalid_drop", 64'(r_dvalid[1]), 64'(0));

    // Three reads to three banks in one cycle.
    r_avalid = 3'b111; r_addr[0] = 6'd0; r_addr[1] = 6'd1; r_addr[2] = 6'd2;
    step(er, ew, obr, obw);
    chk("par_aready", 64'(obr), 64'(3'b111));
    chk("par_dvalid", 64'(r_dvalid), 64'(3'b111));
    r_avalid = '0;

    // Three writers on bank 0, grants rotate 0,1,2 after reset.
    do_reset();
    v0 = $urandom; v4 = $urandom; v8 = $urandom;
    w_addr[0] = 6'd0; w_data[0] = v0;
    w_addr[1] = 6'd4; w_data[1] = v4;
    w_addr[2] = 6'd8; w_data[2] = v8;
    w_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      logic [WP-1:0] want;
      want = WP'(1) << k;
      step(er, ew, obr, obw);
      chk($sformatf("wr_order%0d", k), 64'(obw), 64'(want));
      w_valid = w_valid & ~obw;
    end
    w_valid = '0;
    r_avalid = 3'b001; r_addr[0] = 6'd0; step(er, ew, obr, obw);
    chk("rb_0", 64'(r_data[0]), 64'(v0));
    r_addr[0] = 6'd4; step(er, ew, obr, obw);
    chk("rb_4", 64'(r_data[0]), 64'(v4));
    r_addr[0] = 6'd8; step(er, ew, obr, obw);
    chk("rb_8", 64'(r_data[0]), 64'(v8));
    r_avalid = '0;

    // Same-row read and write: read-first.
    w_valid = 3'b001; w_addr[0] = 6'd3; w_data[0] = 32'h7;
    step(er, ew, obr, obw);
    w_valid = 3'b010; w_addr[1] = 6'd3; w_data[1] = 32'h1;
    r_avalid = 3'b100; r_addr[2] = 6'd3;
    step(er, ew, obr, obw);
    chk("rfirst_old", 64'(r_data[2]), 64'(32'h7));
    w_valid = '0;
    step(er, ew, obr, obw);
    chk("rfirst_new", 64'(r_data[2]), 64'(32'h1));
    r_avalid = '0;

    // Reset while a read return is pending.
    r_avalid = 3'b001; r_addr[0] = 6'd9;
    step(er, ew, obr, obw);
    r_avalid = '0;
    chk("pend_dvalid", 64'(r_dvalid[0]), 64'(1));
    do_reset();
    r_avalid = 3'b111; r_addr[0] = 6'd1; r_addr[1] = 6'd5; r_addr[2] = 6'd9;
    step(er, ew, obr, obw);
    chk("post_rst_winner", 64'(obr), 64'(3'b001));
    r_avalid = '0;

    // Randomized traffic; refused requesters hold their request.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < RP; p++)
        if (!r_avalid[p] && $urandom_range(0, 1) == 1) begin
          r_avalid[p] = 1'b1; r_addr[p] = AW'($urandom);
        end
      for (int p = 0; p < WP; p++)
        if (!w_valid[p] && $urandom_range(0, 1) == 1) begin
          w_valid[p] = 1'b1; w_addr[p] = AW'($urandom); w_data[p] = $urandom;
        end
      step(er, ew, obr, obw);
      r_avalid = r_avalid & ~er;
      w_valid  = w_valid & ~ew;
    end
    r_avalid = '0;
    w_valid  = '0;
    step(er, ew, obr, obw);

`ifdef MBM_PERF_CNT_EN
    // Two readers held on bank 2: one refused per cycle.
    do_reset();
    r_avalid = 3'b011; r_addr[0] = 6'd2; r_addr[1] = 6'd6;
    for (int k = 0; k < 10; k++) step(er, ew, obr, obw);
    r_avalid = '0;
    chk("cnt_bank2", 64'(conflict_cnt[2]), 64'(10));
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("cnt_model%0d", b), 64'(conflict_cnt[b]), 64'(e_cnt[b]));
      if (b != 2) chk($sformatf("cnt_bank%0d", b), 64'(conflict_cnt[b]), 64'(0));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
